// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the SRAM arbiter slice
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;
  localparam int WORD_W  = 32;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - per-half wait-state down-counter, last_cycle at zero
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WAIT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last_cycle = (cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port 32-bit request arbiter sequencing 16-bit SRAM halves
// SRAM_ARB_RR_EN selects round-robin arbitration; fixed port 0 priority otherwise.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_read,
  input  logic                  p0_write,
  input  logic [SRAM_AW-2:0]    p0_addr,
  input  logic [WORD_W-1:0]     p0_wdata,
  output logic                  p0_not_ready,
  input  logic                  p1_read,
  input  logic                  p1_write,
  input  logic [SRAM_AW-2:0]    p1_addr,
  input  logic [WORD_W-1:0]     p1_wdata,
  output logic                  p1_not_ready,
  output logic [WORD_W-1:0]     rdata,
  output logic [SRAM_AW-1:0]    SRAMaddress,
  output logic                  SRAMWEn,
  inout  wire  [SRAM_DW-1:0]    SRAMdata
);

  state_t               state;
  logic                 grant;
  logic                 op_write;
  logic [SRAM_AW-2:0]   addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [SRAM_DW-1:0]   rdata_lo;
  logic [WORD_W-1:0]    rdata_q;

  logic                 req0, req1, any_req, win;
  logic                 last_cycle, load;
  logic                 drive_en;
  logic [SRAM_DW-1:0]   wdata_half;

  assign req0    = p0_read | p0_write;
  assign req1    = p1_read | p1_write;
  assign any_req = req0 | req1;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_grant;
  end
`else
  always_comb begin
    win = req1 & ~req0;
  end
`endif

  // Timer restarts on entry to each half: IDLE->LO and LO->HI.
  assign load = ((state == IDLE) && any_req) || ((state == LO) && last_cycle);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_lo <= '0;
      rdata_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= win;
            op_write <= win ? p1_write : p0_write;
            addr_q   <= win ? p1_addr  : p0_addr;
            wdata_q  <= win ? p1_wdata : p0_wdata;
`ifdef SRAM_ARB_RR_EN
            last_grant <= win;
`endif
            state    <= LO;
          end
        end
        LO: begin
          if (last_cycle) begin
            if (!op_write) rdata_lo <= SRAMdata;
            state <= HI;
          end
        end
        HI: begin
          if (last_cycle) begin
            if (!op_write) rdata_q <= {SRAMdata, rdata_lo};
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // WEn is released in the final hold cycle of each half so data stays valid past the strobe.
  always_comb begin
    SRAMaddress = '0;
    SRAMWEn     = 1'b1;
    drive_en    = 1'b0;
    wdata_half  = '0;
    case (state)
      LO: begin
        SRAMaddress = {addr_q, 1'b0};
        wdata_half  = wdata_q[SRAM_DW-1:0];
        drive_en    = op_write;
        SRAMWEn     = ~(op_write & ~last_cycle);
      end
      HI: begin
        SRAMaddress = {addr_q, 1'b1};
        wdata_half  = wdata_q[WORD_W-1:SRAM_DW];
        drive_en    = op_write;
        SRAMWEn     = ~(op_write & ~last_cycle);
      end
      default: ;
    endcase
  end

  assign SRAMdata = drive_en ? wdata_half : {SRAM_DW{1'bz}};
  assign rdata    = rdata_q;

  assign p0_not_ready = req0 & ~((state == DONE) && (grant == 1'b0));
  assign p1_not_ready = req1 & ~((state == DONE) && (grant == 1'b1));

endmodule
